fir_mcm_pipe: RTL and testbench

Parametrised, pipelined transposed-form FIR filter that generalises the fixed 3-coefficient combinational multiple-constant multiplier. It supports any tap count and coefficient set, adds a persistent delay line, a valid/ready handshake on both sides and a synchronous flush. It sits between a sample source and downstream DSP stages. All constant products of one input sample come from a shared shift-add MCM network, not from generic multipliers.

---
 rtl/fir_mcm_pkg.sv | 40 ++++
 rtl/fir_mcm_pipe_if.sv | 21 ++
 rtl/fir_mcm_pipe_mcm.sv | 60 ++++++
 rtl/fir_mcm_pipe.sv | 84 ++++++++
 tb/tb_fir_mcm_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mcm_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined MCM FIR.
package fir_mcm_pkg;

  localparam int TAPS_MIN = 2;
  localparam int TAPS_MAX = 16;

  // c_0 sits in the low byte and is applied to the newest sample
  localparam logic [23:0] FIR_DEFAULT_COEFS = {8'sd97, 8'sd45, 8'sd23};

  // Full-precision output width: product width plus log2 growth of the sum
  function automatic int fir_out_w(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Canonical signed digit of coefficient c at bit position pos.
  // Returns {neg, pos}: 2'b01 = +1, 2'b10 = -1, 2'b00 = 0.
  function automatic logic [1:0] csd_digit(int c, int pos);
    int v;
    logic [1:0] d;
    logic [1:0] dig;
    v = c;
    d = 2'b00;
    for (int i = 0; i <= pos; i++) begin
      dig = 2'b00;
      if (v[0]) begin
        if (v[1] == 1'b0) begin
          dig = 2'b01;
          v   = v - 1;
        end else begin
          dig = 2'b10;
          v   = v + 1;
        end
      end
      if (i == pos) d = dig;
      v = v >>> 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/fir_mcm_pipe_if.sv
// Sample-in / result-out stream bundle with valid/ready on both sides.
interface fir_mcm_pipe_if
  import fir_mcm_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int OUT_W  = fir_out_w(DATA_W, 8, 3)
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;

  // Source/sink side: supplies samples, consumes results
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  // Filter side
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/fir_mcm_pipe_mcm.sv
// Multiple-constant multiplier: every product c_k*x is built from CSD
// shift-add terms; each shifted copy of x is generated once and shared
// by all coefficients that have a non-zero digit at that position.
module mcm_shift_add
  import fir_mcm_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter logic [TAPS*COEF_W-1:0] COEFS = FIR_DEFAULT_COEFS,
  parameter int OUT_W  = fir_out_w(DATA_W, COEF_W, TAPS)
) (
  input  logic signed [DATA_W-1:0]      x_i,
  output logic [TAPS-1:0][OUT_W-1:0]    prod_o
);
  // A signed COEF_W value needs at most COEF_W+1 CSD digits
  localparam int NPOS = COEF_W + 1;

  function automatic bit pos_used(int s);
    bit u;
    u = 1'b0;
    for (int k = 0; k < TAPS; k++)
      if (csd_digit(int'($signed(COEFS[k*COEF_W +: COEF_W])), s) != 2'b00) u = 1'b1;
    return u;
  endfunction

  // Shared shifted copies of the sign-extended sample, only where some tap needs them
  for (genvar s = 0; s < NPOS; s++) begin : g_sh
    if (pos_used(s)) begin : g_on
      logic [OUT_W-1:0] v;
      assign v = {{(OUT_W-DATA_W){x_i[DATA_W-1]}}, x_i} << s;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    localparam int CK = int'($signed(COEFS[k*COEF_W +: COEF_W]));
    logic [NPOS-1:0][OUT_W-1:0] term;
    logic [OUT_W-1:0]           acc;

    for (genvar s = 0; s < NPOS; s++) begin : g_dig
      localparam logic [1:0] D = csd_digit(CK, s);
      if (D == 2'b01) begin : g_p
        assign term[s] = g_sh[s].g_on.v;
      end else if (D == 2'b10) begin : g_n
        assign term[s] = -g_sh[s].g_on.v;
      end else begin : g_z
        assign term[s] = '0;
      end
    end

    // Sum the signed digit terms of this coefficient
    always_comb begin
      acc = '0;
      for (int i = 0; i < NPOS; i++) acc = acc + term[i];
    end

    assign prod_o[k] = acc;
  end

endmodule

// File: rtl/fir_mcm_pipe.sv
// Two-stage transposed-form FIR: stage 1 registers all constant products of
// the accepted sample, stage 2 holds the transposed partial-sum chain and y.
// Both stages move together on adv, so a stalled output freezes everything.
module fir_mcm_pipe
  import fir_mcm_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int TAPS   = 3,
  parameter int COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFS = FIR_DEFAULT_COEFS,
  parameter int OUT_W  = fir_out_w(DATA_W, COEF_W, TAPS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  fir_mcm_pipe_if.slave  s
);

  if (TAPS < TAPS_MIN || TAPS > TAPS_MAX) begin : g_bad_taps
    $error("fir_mcm_pipe: TAPS=%0d outside %0d..%0d", TAPS, TAPS_MIN, TAPS_MAX);
  end
  if (OUT_W != fir_out_w(DATA_W, COEF_W, TAPS)) begin : g_bad_out_w
    $error("fir_mcm_pipe: OUT_W=%0d must equal %0d", OUT_W, fir_out_w(DATA_W, COEF_W, TAPS));
  end

  logic                           adv;
  logic [TAPS-1:0][OUT_W-1:0]     prod;
  logic [TAPS-1:0][OUT_W-1:0]     p_q;
  logic                           v1_q;
  logic                           v2_q;
  logic [TAPS-1:1][OUT_W-1:0]     z_q, z_d;
  logic [OUT_W-1:0]               y_q, y_d;

  // Pipeline moves whenever the output register is empty or being drained
  assign adv        = !v2_q || s.out_ready;
  assign s.in_ready = adv && !clear && !rst;
  assign s.out_data = y_q;
  assign s.out_valid = v2_q;

  mcm_shift_add #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .COEFS  (COEFS),
    .OUT_W  (OUT_W)
  ) u_mcm (
    .x_i    (s.in_data),
    .prod_o (prod)
  );

  // Transposed chain: each partial sum adds its product to the next one down
  always_comb begin
    z_d = '0;
    y_d = p_q[0] + z_q[1];
    for (int k = 1; k < TAPS-1; k++) z_d[k] = p_q[k] + z_q[k+1];
    z_d[TAPS-1] = p_q[TAPS-1];
  end

  // Stage 1: capture products of an accepted sample
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      v1_q <= s.in_valid;
      if (s.in_valid) p_q <= prod;
    end
  end

  // Stage 2: bubbles clear v2 but leave the delay line untouched
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      v2_q <= 1'b0;
      z_q  <= '0;
      y_q  <= '0;
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        z_q <= z_d;
        y_q <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_fir_mcm_pipe.sv
// Bench for fir_mcm_pipe: default 3-tap instance plus a 5-tap instance,
// checked against a convolution model over the accepted-sample history.
module tb_fir_mcm_pipe;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_mcm_pipe_if #(.DATA_W(12), .OUT_W(22)) if0 ();
  fir_mcm_pipe_if #(.DATA_W(8),  .OUT_W(17)) if1 ();

  fir_mcm_pipe dut0 (.clk(clk), .rst(rst), .clear(clear), .s(if0));

  fir_mcm_pipe #(
    .DATA_W (8),
    .TAPS   (5),
    .COEF_W (6),
    .COEFS  ({-6'sd3, 6'sd17, 6'sd0, -6'sd1, 6'sd2})
  ) dut1 (.clk(clk), .rst(rst), .clear(clear), .s(if1));

  // Reference model: coefficients as plain integers, history of accepted samples
  int c0[3] = '{23, 45, 97};
  int c1[5] = '{2, -1, 0, 17, -3};
  int h0[3];
  int h1[5];
  int q0[$];
  int q1[$];

  // Observations of the last step
  logic   ir0, ov0, ir1, ov1;
  integer od0, od1;
  bit     xf0, hv0, xf1, hv1;
  int     ev0, ev1;

  // One cycle on dut0: drive at negedge, observe, update model, advance
  task automatic step0(input bit iv, input int id, input bit ordy, input bit clr, input bit rs);
    logic [11:0] d12;
    int acc;
    d12 = id[11:0];
    if0.in_valid = iv; if0.in_data = d12; if0.out_ready = ordy; clear = clr; rst = rs;
    #1;
    ir0 = if0.in_ready; ov0 = if0.out_valid; od0 = if0.out_data;
    xf0 = (ov0 === 1'b1) && ordy && !clr && !rs;
    hv0 = 1'b0; ev0 = 0;
    if (clr || rs) begin
      foreach (h0[k]) h0[k] = 0;
      q0.delete();
    end else begin
      if (xf0 && q0.size() > 0) begin hv0 = 1'b1; ev0 = q0.pop_front(); end
      if (iv && ir0 === 1'b1) begin
        for (int k = 2; k > 0; k--) h0[k] = h0[k-1];
        h0[0] = int'($signed(d12));
        acc = 0;
        foreach (c0[k]) acc += c0[k] * h0[k];
        q0.push_back(acc);
      end
    end
    @(negedge clk);
  endtask

  task automatic step1(input bit iv, input int id, input bit ordy, input bit clr, input bit rs);
    logic [7:0] d8;
    int acc;
    d8 = id[7:0];
    if1.in_valid = iv; if1.in_data = d8; if1.out_ready = ordy; clear = clr; rst = rs;
    #1;
    ir1 = if1.in_ready; ov1 = if1.out_valid; od1 = if1.out_data;
    xf1 = (ov1 === 1'b1) && ordy && !clr && !rs;
    hv1 = 1'b0; ev1 = 0;
    if (clr || rs) begin
      foreach (h1[k]) h1[k] = 0;
      q1.delete();
    end else begin
      if (xf1 && q1.size() > 0) begin hv1 = 1'b1; ev1 = q1.pop_front(); end
      if (iv && ir1 === 1'b1) begin
        for (int k = 4; k > 0; k--) h1[k] = h1[k-1];
        h1[0] = int'($signed(d8));
        acc = 0;
        foreach (c1[k]) acc += c1[k] * h1[k];
        q1.push_back(acc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step0(0, 0, 1, 0, 1);
    step0(0, 0, 1, 0, 1);
    step0(0, 0, 1, 0, 1);
    checks += 3;
    if (ir0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", ir0); end
    if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    if (od0 !== 0)    begin errors++; $display("FAIL reset_out_data: got %0d want 0", od0); end
    step0(0, 0, 1, 0, 0);
    checks++;
    if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", ir0); end
  endtask

  task automatic test_impulse();
    int exp_v[4] = '{23, 45, 97, 0};
    int outs[$];
    int first = -1;
    for (int i = 0; i < 10; i++) begin
      step0(i < 4, (i == 0) ? 1 : 0, 1, 0, 0);
      if (xf0) begin
        checks++;
        if (!hv0 || od0 !== ev0) begin errors++; $display("FAIL impulse_model: got %0d want %0d", od0, ev0); end
        outs.push_back(od0);
        if (first < 0) first = i;
      end
    end
    checks += 2;
    if (first != 2) begin errors++; $display("FAIL impulse_latency: got %0d want 2", first); end
    if (outs.size() != 4) begin errors++; $display("FAIL impulse_count: got %0d want 4", outs.size()); end
    for (int k = 0; k < 4 && k < outs.size(); k++) begin
      checks++;
      if (outs[k] != exp_v[k]) begin errors++; $display("FAIL impulse_y%0d: got %0d want %0d", k, outs[k], exp_v[k]); end
    end
  endtask

  task automatic test_step_sign();
    int exp_p[3] = '{161, 476, 1155};
    int exp_n[3] = '{-47104, -139264, -337920};
    int outs[$];
    for (int pass = 0; pass < 2; pass++) begin
      outs.delete();
      if (pass == 1) step0(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
        step0(i < 3, (pass == 0) ? 7 : -2048, 1, 0, 0);
        if (xf0) begin
          checks++;
          if (!hv0 || od0 !== ev0) begin errors++; $display("FAIL step_model: got %0d want %0d", od0, ev0); end
          outs.push_back(od0);
        end
      end
      checks++;
      if (outs.size() != 3) begin errors++; $display("FAIL step_count%0d: got %0d want 3", pass, outs.size()); end
      for (int k = 0; k < 3 && k < outs.size(); k++) begin
        checks++;
        if (outs[k] != ((pass == 0) ? exp_p[k] : exp_n[k])) begin
          errors++;
          $display("FAIL step_y%0d_%0d: got %0d want %0d", pass, k, outs[k], (pass == 0) ? exp_p[k] : exp_n[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_v[6] = '{23, 91, 256, 421, 586, 751};
    int outs[$];
    int idx = 0;
    integer held = 0;
    bit ordy;
    step0(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      ordy = !(i >= 3 && i <= 5);
      step0(idx < 6, idx + 1, ordy, 0, 0);
      if (idx < 6 && ir0 === 1'b1) idx++;
      if (i >= 3 && i <= 5) begin
        checks += 2;
        if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b want 1", ov0); end
        if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", ir0); end
        if (i == 3) held = od0;
        else begin
          checks++;
          if (od0 !== held) begin errors++; $display("FAIL bp_data_stable: got %0d want %0d", od0, held); end
        end
      end
      if (xf0) begin
        checks++;
        if (!hv0 || od0 !== ev0) begin errors++; $display("FAIL bp_model: got %0d want %0d", od0, ev0); end
        outs.push_back(od0);
      end
    end
    checks++;
    if (outs.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", outs.size()); end
    for (int k = 0; k < 6 && k < outs.size(); k++) begin
      checks++;
      if (outs[k] != exp_v[k]) begin errors++; $display("FAIL bp_y%0d: got %0d want %0d", k, outs[k], exp_v[k]); end
    end
  endtask

  task automatic test_bubbles();
    bit iv_pat[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    bit ov_pat[8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int exp_v[2]  = '{23, 68};
    int n = 0;
    step0(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step0(iv_pat[i], 1, 1, 0, 0);
      checks++;
      if (ov0 !== ov_pat[i]) begin errors++; $display("FAIL bubble_valid%0d: got %b want %b", i, ov0, ov_pat[i]); end
      if (xf0 && n < 2) begin
        checks++;
        if (od0 !== exp_v[n]) begin errors++; $display("FAIL bubble_y%0d: got %0d want %0d", n, od0, exp_v[n]); end
        n++;
      end
    end
  endtask

  // Two results in flight, then flush by clear (use_rst=0) or rst (use_rst=1)
  task automatic test_flush(input bit use_rst);
    int outs[$];
    step0(0, 0, 0, 1, 0);
    step0(1, 9, 0, 0, 0);
    step0(1, 9, 0, 0, 0);
    step0(1, 3, 0, !use_rst, use_rst);
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL flush%0d_inflight: got %b want 1", use_rst, ov0); end
    step0(0, 0, 1, 0, 0);
    checks += 3;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL flush%0d_out_valid: got %b want 0", use_rst, ov0); end
    if (od0 !== 0)    begin errors++; $display("FAIL flush%0d_out_data: got %0d want 0", use_rst, od0); end
    if (ir0 !== 1'b1) begin errors++; $display("FAIL flush%0d_in_ready: got %b want 1", use_rst, ir0); end
    for (int i = 0; i < 6; i++) begin
      step0(i == 0, 5, 1, 0, 0);
      if (xf0) outs.push_back(od0);
    end
    checks++;
    if (outs.size() != 1 || outs[0] != 115) begin
      errors++;
      $display("FAIL flush%0d_after: got %0d results, first %0d, want one result 115", use_rst, outs.size(),
               (outs.size() > 0) ? outs[0] : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] r12;
    int nout = 0;
    step0(0, 0, 0, 1, 0);
    for (int i = 0; i < 206; i++) begin
      r12 = 12'($urandom);
      step0(i < 200, int'($signed(r12)), 1, 0, 0);
      if (i < 200) begin
        checks++;
        if (ir0 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, ir0); end
      end
      if (xf0) begin
        nout++;
        checks++;
        if (!hv0 || od0 !== ev0) begin errors++; $display("FAIL b2b_model: got %0d want %0d", od0, ev0); end
      end
    end
    checks++;
    if (nout != 200) begin errors++; $display("FAIL b2b_count: got %0d want 200", nout); end
  endtask

  task automatic test_param_impulse();
    int exp_v[5] = '{2, -1, 0, 17, -3};
    int outs[$];
    int first = -1;
    step1(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step1(i < 5, (i == 0) ? 1 : 0, 1, 0, 0);
      if (xf1) begin
        outs.push_back(od1);
        if (first < 0) first = i;
      end
    end
    checks += 2;
    if (first != 2) begin errors++; $display("FAIL p5_latency: got %0d want 2", first); end
    if (outs.size() != 5) begin errors++; $display("FAIL p5_count: got %0d want 5", outs.size()); end
    for (int k = 0; k < 5 && k < outs.size(); k++) begin
      checks++;
      if (outs[k] != exp_v[k]) begin errors++; $display("FAIL p5_y%0d: got %0d want %0d", k, outs[k], exp_v[k]); end
    end
  endtask

  task automatic test_param_random();
    logic [7:0] r8;
    int sent = 0;
    int cyc = 0;
    bit iv, ordy, clr;
    bit p_ov = 0, p_ordy = 0, p_clr = 0;
    integer p_od = 0;
    step1(0, 0, 0, 1, 0);
    while (sent < 1000 && cyc < 20000) begin
      r8   = 8'($urandom);
      iv   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 199) == 0);
      ordy = clr ? 1'b0 : ($urandom_range(0, 9) < 7);
      step1(iv, int'($signed(r8)), ordy, clr, 0);
      cyc++;
      checks++;
      if (ir1 !== ((!ov1 || ordy) && !clr)) begin
        errors++; $display("FAIL rnd_in_ready c%0d: got %b ov %b ordy %b clr %b", cyc, ir1, ov1, ordy, clr);
      end
      if (p_ov && !p_ordy && !p_clr) begin
        checks++;
        if (ov1 !== 1'b1 || od1 !== p_od) begin
          errors++; $display("FAIL rnd_hold c%0d: got %b/%0d want 1/%0d", cyc, ov1, od1, p_od);
        end
      end
      if (xf1) begin
        checks++;
        if (!hv1 || od1 !== ev1) begin errors++; $display("FAIL rnd_model c%0d: got %0d want %0d", cyc, od1, ev1); end
      end
      if (iv && ir1 === 1'b1 && !clr) sent++;
      p_ov = (ov1 === 1'b1); p_ordy = ordy; p_clr = clr; p_od = od1;
    end
    checks++;
    if (sent < 1000) begin errors++; $display("FAIL rnd_budget: sent %0d want 1000", sent); end
    for (int i = 0; i < 6; i++) begin
      step1(0, 0, 1, 0, 0);
      if (xf1) begin
        checks++;
        if (!hv1 || od1 !== ev1) begin errors++; $display("FAIL rnd_drain: got %0d want %0d", od1, ev1); end
      end
    end
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d pending want 0", q1.size()); end
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
    foreach (h0[k]) h0[k] = 0;
    foreach (h1[k]) h1[k] = 0;
    test_reset();
    test_impulse();
    test_step_sign();
    test_backpressure();
    test_bubbles();
    test_flush(1'b0);
    test_flush(1'b1);
    test_back_to_back();
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    test_param_impulse();
    test_param_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
